// File: rtl/ysyx_24080014_lsu_pkg.sv
// ysyx_24080014_lsu_pkg: LSU state encoding, RV32 load/store funct3 codes and alignment check
package ysyx_24080014_lsu_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'b01) ? off[0] : (f3[1:0] == 2'b10) ? (off != 2'b00) : 1'b0;
    endfunction
endpackage

// File: rtl/ysyx_24080014_lsu_ctrl_if.sv
// ysyx_24080014_lsu_ctrl_if: EXU request, memory access and WBU result channels of the LSU
interface ysyx_24080014_lsu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_wen_rf;
    logic        out_misalign;
    logic        out_err;
    modport slave (
        input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
        input  mem_ready, mem_rdata, out_ready,
        output in_ready, mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
        output out_valid, out_rdata, out_rd, out_wen_rf, out_misalign, out_err
    );
    modport master (
        output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_rd,
        output mem_ready, mem_rdata, out_ready,
        input  in_ready, mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
        input  out_valid, out_rdata, out_rd, out_wen_rf, out_misalign, out_err
    );
endinterface

// File: rtl/ysyx_24080014_lsu_align.sv
// ysyx_24080014_lsu_align: byte-lane mask/data shifting, load extraction and misalign detection
module ysyx_24080014_lsu_align
    import ysyx_24080014_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [7:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);
    logic [3:0]  w_base;
    logic [31:0] w_sh;
    assign w_base = (i_funct3 == F3_SB) ? 4'b0001 : (i_funct3 == F3_SH) ? 4'b0011 : 4'b1111;
    assign o_wmask = {4'b0000, w_base << i_off};
    assign o_wdata = i_wdata << {i_off, 3'b000};
    assign w_sh = i_rdata >> {i_off, 3'b000};
    assign o_rdata = (i_funct3 == F3_LB)  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                     (i_funct3 == F3_LH)  ? {{16{w_sh[15]}}, w_sh[15:0]} :
                     (i_funct3 == F3_LBU) ? {24'd0, w_sh[7:0]} :
                     (i_funct3 == F3_LHU) ? {16'd0, w_sh[15:0]} : w_sh;
    assign o_misalign = misaligned(i_funct3, i_off);
endmodule

// File: rtl/ysyx_24080014_lsu_ctrl.sv
// ysyx_24080014_lsu_ctrl: load/store control FSM between EXU and the memory access unit
module ysyx_24080014_lsu_ctrl
    import ysyx_24080014_lsu_pkg::*;
#(
    parameter int STORE_LAT = 2,
    parameter int TIMEOUT   = 255
) (
    input logic clk,
    input logic rst,
    ysyx_24080014_lsu_ctrl_if.slave lsu
);
    localparam logic [7:0] L_ST = 8'(STORE_LAT - 1);
    localparam logic [7:0] L_TO = 8'(TIMEOUT);
    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_f3;
    logic [4:0]  r_rd;
    logic [7:0]  r_cnt;
    logic        r_load, r_store, r_mis, r_err;
    logic [2:0]  w_f3;
    logic [1:0]  w_off;
    logic [7:0]  w_wmask;
    logic [31:0] w_wdata, w_ext;
    logic        w_mis, w_legal, w_ok, w_busy, w_done, w_tmo;
    // In IDLE the aligner looks at the incoming request so misalignment is known at accept time
    assign w_f3  = (r_state == S_IDLE) ? lsu.in_funct3 : r_f3;
    assign w_off = (r_state == S_IDLE) ? lsu.in_addr[1:0] : r_addr[1:0];
    ysyx_24080014_lsu_align u_align (
        .i_funct3   (w_f3),
        .i_off      (w_off),
        .i_wdata    (r_wdata),
        .i_rdata    (lsu.mem_rdata),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ext),
        .o_misalign (w_mis)
    );
    assign w_legal = (lsu.in_is_load && !lsu.in_is_store &&
                      (lsu.in_funct3 == F3_LB || lsu.in_funct3 == F3_LH || lsu.in_funct3 == F3_LW ||
                       lsu.in_funct3 == F3_LBU || lsu.in_funct3 == F3_LHU)) ||
                     (lsu.in_is_store && !lsu.in_is_load &&
                      (lsu.in_funct3 == F3_SB || lsu.in_funct3 == F3_SH || lsu.in_funct3 == F3_SW));
    assign w_ok   = w_legal && !w_mis;
    assign w_busy = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_done = lsu.mem_ready || (r_store && r_cnt == L_ST);
    assign w_tmo  = !w_done && r_cnt == L_TO;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = lsu.in_valid ? (w_ok ? S_REQ : S_RESP) : S_IDLE;
            S_REQ:   w_next = S_WAIT;
            S_WAIT:  w_next = (w_done || w_tmo) ? S_RESP : S_WAIT;
            S_RESP:  w_next = lsu.out_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_f3    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_load  <= 1'b0;
            r_store <= 1'b0;
            r_mis   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && lsu.in_valid) begin
                r_addr  <= lsu.in_addr;
                r_wdata <= lsu.in_wdata;
                r_f3    <= lsu.in_funct3;
                r_rd    <= lsu.in_rd;
                r_load  <= lsu.in_is_load && !lsu.in_is_store;
                r_store <= lsu.in_is_store && !lsu.in_is_load;
                r_mis   <= w_legal && w_mis;
                r_err   <= !w_legal;
                r_rdata <= '0;
            end
            if (r_state == S_REQ) r_cnt <= '0;
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
                if (lsu.mem_ready && r_load) r_rdata <= w_ext;
                if (w_tmo) r_err <= 1'b1;
            end
        end
    end
    assign lsu.in_ready     = (r_state == S_IDLE);
    assign lsu.mem_ren      = (r_state == S_REQ) && r_load;
    assign lsu.mem_wen      = (r_state == S_REQ) && r_store;
    assign lsu.mem_raddr    = (w_busy && r_load) ? {r_addr[31:2], 2'b00} : 32'd0;
    assign lsu.mem_waddr    = (w_busy && r_store) ? {r_addr[31:2], 2'b00} : 32'd0;
    assign lsu.mem_wdata    = (w_busy && r_store) ? w_wdata : 32'd0;
    assign lsu.mem_wmask    = (w_busy && r_store) ? w_wmask : 8'd0;
    assign lsu.out_valid    = (r_state == S_RESP);
    assign lsu.out_rdata    = (r_state == S_RESP) ? r_rdata : 32'd0;
    assign lsu.out_rd       = (r_state == S_RESP && r_load) ? r_rd : 5'd0;
    assign lsu.out_wen_rf   = (r_state == S_RESP) && r_load && !r_mis && !r_err;
    assign lsu.out_misalign = (r_state == S_RESP) && r_mis;
    assign lsu.out_err      = (r_state == S_RESP) && r_err;
endmodule

// File: tb/tb_ysyx_24080014_lsu_ctrl.sv
// tb_ysyx_24080014_lsu_ctrl: directed scoreboard bench for the LSU control stage
module tb_ysyx_24080014_lsu_ctrl;
    localparam int STORE_LAT = 2;
    localparam int TIMEOUT   = 255;
    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        wen_rf;
        logic        mis;
        logic        err;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    ysyx_24080014_lsu_ctrl_if bus ();
    ysyx_24080014_lsu_ctrl #(.STORE_LAT(STORE_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (bus)
    );
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] rdata,
                                   input logic [4:0] rd, input logic ready);
        exp_t e;
        logic legal, mis;
        int   off;
        e = '{rdata: 32'd0, rd: 5'd0, wen_rf: 1'b0, mis: 1'b0, err: 1'b0};
        off = int'(addr[1:0]);
        legal = (ld && !st && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                (st && !ld && (f3 inside {3'b000, 3'b001, 3'b010}));
        mis = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        if (ld && !st) e.rd = rd;
        if (!legal) e.err = 1'b1;
        else if (mis) e.mis = 1'b1;
        else if (ld && !ready) e.err = 1'b1;
        else if (ld) begin
            e.wen_rf = 1'b1;
            case (f3)
                3'b000:  e.rdata = {{24{rdata[8*off+7]}}, rdata[8*off +: 8]};
                3'b001:  e.rdata = {{16{rdata[8*off+15]}}, rdata[8*off +: 16]};
                3'b100:  e.rdata = {24'd0, rdata[8*off +: 8]};
                3'b101:  e.rdata = {16'd0, rdata[8*off +: 16]};
                default: e.rdata = rdata;
            endcase
        end
        return e;
    endfunction
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                         input logic ready, input logic push);
        bus.in_valid = 1'b1;
        bus.in_is_load = ld;
        bus.in_is_store = st;
        bus.in_funct3 = f3;
        bus.in_addr = addr;
        bus.in_wdata = wd;
        bus.in_rd = rd;
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        if (push) q.push_back(model(ld, st, f3, addr, rdata, rd, ready));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_is_load = 1'b0;
        bus.in_is_store = 1'b0;
    endtask
    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_rdata"}, bus.out_rdata, e.rdata);
        chk({tag, "_rd"}, 32'(bus.out_rd), 32'(e.rd));
        chk({tag, "_wen_rf"}, 32'(bus.out_wen_rf), 32'(e.wen_rf));
        chk({tag, "_misalign"}, 32'(bus.out_misalign), 32'(e.mis));
        chk({tag, "_err"}, 32'(bus.out_err), 32'(e.err));
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    endtask
    task automatic wait_resp(input string tag, input int c0, input int ready_after,
                             input logic [31:0] rdata, input int hold, output int cyc);
        exp_t e;
        cyc = c0;
        while (bus.out_valid !== 1'b1 && cyc < 400) begin
            bus.mem_ready = (cyc == ready_after);
            bus.mem_rdata = (cyc == ready_after) ? rdata : 32'h0;
            @(negedge clk);
            cyc++;
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        if (bus.out_valid !== 1'b1) begin
            chk({tag, "_resp_timeout"}, 32'(bus.out_valid), 32'd1);
        end else if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
            chk_out(tag, e);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk_out({tag, "_hold"}, e);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
            chk({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
        end
    endtask
    task automatic chk_req(input string tag, input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [7:0] mask, input logic [31:0] wd);
        chk({tag, "_ren"}, 32'(bus.mem_ren), 32'(ren));
        chk({tag, "_wen"}, 32'(bus.mem_wen), 32'(wen));
        if (ren) chk({tag, "_raddr"}, bus.mem_raddr, addr);
        if (wen) begin
            chk({tag, "_waddr"}, bus.mem_waddr, addr);
            chk({tag, "_wmask"}, 32'(bus.mem_wmask), 32'(mask));
            chk({tag, "_wdata"}, bus.mem_wdata, wd);
        end
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_ren"}, 32'(bus.mem_ren), 32'd0);
        chk({tag, "_wen"}, 32'(bus.mem_wen), 32'd0);
        chk({tag, "_addrs"}, bus.mem_raddr | bus.mem_waddr | bus.mem_wdata, 32'd0);
        chk({tag, "_wmask"}, 32'(bus.mem_wmask), 32'd0);
        chk({tag, "_outs"}, {bus.out_rdata[31:8], bus.out_rdata[7:0] | {bus.out_rd, bus.out_valid,
            bus.out_wen_rf, bus.out_misalign | bus.out_err}}, 32'd0);
    endtask
    initial begin
        int cyc;
        bus.in_valid = 1'b0;
        bus.in_is_load = 1'b0;
        bus.in_is_store = 1'b0;
        bus.in_funct3 = 3'd0;
        bus.in_addr = 32'd0;
        bus.in_wdata = 32'd0;
        bus.in_rd = 5'd0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_quiet("reset");
        // SW with no mem_ready: completes after STORE_LAT wait cycles
        issue(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEADBEEF, 5'd3, 32'h0, 1'b0, 1'b1);
        chk_req("sw_req", 1'b0, 1'b1, 32'h8000_0004, 8'h0F, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_wen_pulse", 32'(bus.mem_wen), 32'd0);
        chk("sw_waddr_hold", bus.mem_waddr, 32'h8000_0004);
        chk("sw_wdata_hold", bus.mem_wdata, 32'hDEADBEEF);
        wait_resp("sw", 1, -1, 32'h0, 0, cyc);
        chk("sw_wait_cycles", 32'(cyc - 1), 32'(STORE_LAT));
        issue(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 5'd0, 32'h0, 1'b0, 1'b1);
        chk_req("sb_req", 1'b0, 1'b1, 32'h8000_0000, 8'h08, 32'hA500_0000);
        wait_resp("sb", 0, 1, 32'h0, 0, cyc);
        chk("sb_ready_early", 32'(cyc), 32'd2);
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 5'd0, 32'h0, 1'b0, 1'b1);
        chk_req("sh_req", 1'b0, 1'b1, 32'h8000_0000, 8'h0C, 32'hBEEF_0000);
        wait_resp("sh", 0, -1, 32'h0, 0, cyc);
        issue(1'b1, 1'b0, 3'b000, 32'h8000_0002, 32'h0, 5'd7, 32'h1280_3456, 1'b1, 1'b1);
        chk_req("lb_req", 1'b1, 1'b0, 32'h8000_0000, 8'h00, 32'h0);
        wait_resp("lb", 0, 3, 32'h1280_3456, 0, cyc);
        issue(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 5'd9, 32'h1280_3456, 1'b1, 1'b1);
        wait_resp("lhu", 0, 1, 32'h1280_3456, 0, cyc);
        chk("lhu_min_latency", 32'(cyc), 32'd2);
        issue(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd10, 32'h8001_0000, 1'b1, 1'b1);
        wait_resp("lh", 0, 2, 32'h8001_0000, 0, cyc);
        issue(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'h0, 5'd11, 32'h0000_F000, 1'b1, 1'b1);
        wait_resp("lbu", 0, 1, 32'h0000_F000, 0, cyc);
        // back-pressure: result must hold for 5 cycles with out_ready low
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 5'd12, 32'h1234_5678, 1'b1, 1'b1);
        chk_req("lw_req", 1'b1, 1'b0, 32'h8000_0008, 8'h00, 32'h0);
        wait_resp("lw_bp", 0, 1, 32'h1234_5678, 5, cyc);
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 5'd13, 32'h0, 1'b1, 1'b1);
        chk("lw_mis_no_ren", 32'(bus.mem_ren), 32'd0);
        wait_resp("lw_mis", 0, -1, 32'h0, 0, cyc);
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0003, 32'h1, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("sh_mis_no_wen", 32'(bus.mem_wen), 32'd0);
        wait_resp("sh_mis", 0, -1, 32'h0, 0, cyc);
        issue(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 5'd14, 32'h0, 1'b1, 1'b1);
        wait_resp("ld_illegal", 0, -1, 32'h0, 0, cyc);
        issue(1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1);
        wait_resp("st_illegal", 0, -1, 32'h0, 0, cyc);
        issue(1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1);
        wait_resp("both_kind", 0, -1, 32'h0, 0, cyc);
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd15, 32'h0, 1'b0, 1'b1);
        wait_resp("lw_tmo", 0, -1, 32'h0, 0, cyc);
        chk("lw_tmo_latency", 32'(cyc >= TIMEOUT && cyc <= TIMEOUT + 2), 32'd1);
        // reset while waiting: late mem_ready must not produce a result
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd16, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_in_wait_raddr", bus.mem_raddr, 32'h8000_0020);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_quiet("rst_wait");
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk_quiet("late_ready");
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
